// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared sizing constants and the entry record for the reorder buffer.
//   ROB_DEPTH  : number of in-flight instructions tracked
//   ROB_IX_W   : width of a ROB index (matches the register file's rob_ix)
//   REG_ADDR_W : architectural register address width
//   XLEN       : data path width
//   rob_entry_t: one slot of the buffer
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_IX_W   = 3;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] rd;
    logic                  writes_rd;
    logic [XLEN-1:0]       value;
    logic                  mispredict;
  } rob_entry_t;

endpackage : reorder_buffer_pkg

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Eight-entry circular reorder buffer. Instructions are allocated in program
// order at the tail, completed out of order by the common data bus, and
// retired in order from the head, one per cycle.
//
// Ports
//   clk_in, rst_in        : clock, synchronous active-high reset
//   alloc_valid_in        : issue stage wants an entry this cycle
//   alloc_rd_in           : destination register of the issuing instruction
//   alloc_writes_rd_in    : issuing instruction writes the register file
//   alloc_rob_ix_out      : index handed to the issuing instruction (tail)
//   full_out, empty_out   : occupancy flags
//   cdb_valid_in          : result broadcast valid
//   cdb_rob_ix_in         : entry the result belongs to
//   cdb_value_in          : result value
//   cdb_mispredict_in     : result is a mispredicted branch
//   lookup_ix_in          : operand bypass index
//   lookup_ready_out      : that entry holds a completed result
//   lookup_value_out      : that entry's result
//   we_out, wa_out,
//   wd_out, wrob_ix_out   : registered commit write to the register file
//   flush_out             : one-cycle pulse after a mispredicted branch retires
//   flush_addrs_out       : per-entry register address to clear during a flush
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 alloc_valid_in,
  input  logic [REG_ADDR_W-1:0]                alloc_rd_in,
  input  logic                                 alloc_writes_rd_in,
  output logic [ROB_IX_W-1:0]                  alloc_rob_ix_out,
  output logic                                 full_out,
  output logic                                 empty_out,
  input  logic                                 cdb_valid_in,
  input  logic [ROB_IX_W-1:0]                  cdb_rob_ix_in,
  input  logic [XLEN-1:0]                      cdb_value_in,
  input  logic                                 cdb_mispredict_in,
  input  logic [ROB_IX_W-1:0]                  lookup_ix_in,
  output logic                                 lookup_ready_out,
  output logic [XLEN-1:0]                      lookup_value_out,
  output logic                                 we_out,
  output logic [REG_ADDR_W-1:0]                wa_out,
  output logic [XLEN-1:0]                      wd_out,
  output logic [ROB_IX_W-1:0]                  wrob_ix_out,
  output logic                                 flush_out,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     flush_addrs_out
);

  // Count needs one extra bit so that "full" (== DEPTH) is representable.
  localparam int               COUNT_W    = $clog2(DEPTH) + 1;
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

  rob_entry_t                entries [DEPTH];
  logic [ROB_IX_W-1:0]       head;
  logic [ROB_IX_W-1:0]       tail;
  logic [COUNT_W-1:0]        count;

  rob_entry_t                head_entry;
  logic                      head_done;
  logic                      commit_fire;
  logic                      flush_commit;
  logic                      alloc_accept;
  logic                      cdb_hit;

  assign full_out         = (count == FULL_COUNT);
  assign empty_out        = (count == '0);
  assign alloc_rob_ix_out = tail;

  // Commit looks only at the registered ready bit, so a result broadcast to
  // the head this cycle retires on the next one at the earliest.
  assign head_entry   = entries[head];
  assign head_done    = head_entry.valid && head_entry.ready;
  assign commit_fire  = head_done && !head_entry.mispredict;
  assign flush_commit = head_done && head_entry.mispredict;

  // full_out is sampled before any commit this cycle, so a full buffer cannot
  // reuse the slot being freed in the same cycle. The flush pulse cycle also
  // refuses allocation so the front end can redirect first.
  assign alloc_accept = alloc_valid_in && !full_out && !flush_out;
  assign cdb_hit      = cdb_valid_in && entries[cdb_rob_ix_in].valid;

  // Operand bypass reads registered state only; no forwarding from the CDB.
  assign lookup_ready_out = entries[lookup_ix_in].valid && entries[lookup_ix_in].ready;
  assign lookup_value_out = entries[lookup_ix_in].value;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      we_out          <= 1'b0;
      wa_out          <= '0;
      wd_out          <= '0;
      wrob_ix_out     <= '0;
      flush_out       <= 1'b0;
      flush_addrs_out <= '0;
    end else begin
      we_out          <= 1'b0;
      flush_out       <= 1'b0;
      flush_addrs_out <= '0;

      if (flush_commit) begin
        // Retiring a mispredicted branch discards everything younger; the
        // flushed destinations are reported so the register file can drop
        // their pending rob_ix tags. Allocation and CDB are ignored.
        flush_out <= 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (entries[i].valid && entries[i].writes_rd && (ROB_IX_W'(i) != head)) begin
            flush_addrs_out[i] <= entries[i].rd;
          end
          entries[i].valid <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (cdb_hit) begin
          entries[cdb_rob_ix_in].ready      <= 1'b1;
          entries[cdb_rob_ix_in].value      <= cdb_value_in;
          entries[cdb_rob_ix_in].mispredict <= cdb_mispredict_in;
        end

        // Register x0 is hardwired, so a commit targeting it never writes.
        if (commit_fire) begin
          we_out               <= head_entry.writes_rd && (head_entry.rd != '0);
          wa_out               <= head_entry.rd;
          wd_out               <= head_entry.value;
          wrob_ix_out          <= head;
          entries[head].valid  <= 1'b0;
          head                 <= head + ROB_IX_W'(1);
        end

        // The tail slot is never valid when allocation is accepted, so this
        // cannot collide with the CDB or commit updates above.
        if (alloc_accept) begin
          entries[tail] <= '{valid:      1'b1,
                             ready:      1'b0,
                             rd:         alloc_rd_in,
                             writes_rd:  alloc_writes_rd_in,
                             value:      '0,
                             mispredict: 1'b0};
          tail          <= tail + ROB_IX_W'(1);
        end

        count <= count + COUNT_W'(alloc_accept) - COUNT_W'(commit_fire);
      end
    end
  end

endmodule : reorder_buffer

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Self-checking bench for reorder_buffer. A reference model keeps the in-flight
// instructions as an ordered queue of ROB indices plus per-index payload, and
// predicts every output. Directed sequences cover the basic scenarios, then a
// long randomized run exercises interleavings.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              alloc_valid_in;
  logic [4:0]        alloc_rd_in;
  logic              alloc_writes_rd_in;
  logic [2:0]        alloc_rob_ix_out;
  logic              full_out;
  logic              empty_out;
  logic              cdb_valid_in;
  logic [2:0]        cdb_rob_ix_in;
  logic [31:0]       cdb_value_in;
  logic              cdb_mispredict_in;
  logic [2:0]        lookup_ix_in;
  logic              lookup_ready_out;
  logic [31:0]       lookup_value_out;
  logic              we_out;
  logic [4:0]        wa_out;
  logic [31:0]       wd_out;
  logic [2:0]        wrob_ix_out;
  logic              flush_out;
  logic [7:0][4:0]   flush_addrs_out;

  int checks = 0;
  int errors = 0;

  // Reference model: program-order queue of occupied indices.
  int          rob_q[$];
  int          tail_m;
  bit          m_ready [8];
  bit          m_wr    [8];
  bit          m_mis   [8];
  logic [4:0]  m_rd    [8];
  logic [31:0] m_val   [8];
  bit          e_we;
  bit          e_flush;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;
  logic [2:0]  e_wix;
  logic [39:0] e_addrs;

  reorder_buffer #(.DEPTH(8)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .alloc_valid_in     (alloc_valid_in),
    .alloc_rd_in        (alloc_rd_in),
    .alloc_writes_rd_in (alloc_writes_rd_in),
    .alloc_rob_ix_out   (alloc_rob_ix_out),
    .full_out           (full_out),
    .empty_out          (empty_out),
    .cdb_valid_in       (cdb_valid_in),
    .cdb_rob_ix_in      (cdb_rob_ix_in),
    .cdb_value_in       (cdb_value_in),
    .cdb_mispredict_in  (cdb_mispredict_in),
    .lookup_ix_in       (lookup_ix_in),
    .lookup_ready_out   (lookup_ready_out),
    .lookup_value_out   (lookup_value_out),
    .we_out             (we_out),
    .wa_out             (wa_out),
    .wd_out             (wd_out),
    .wrob_ix_out        (wrob_ix_out),
    .flush_out          (flush_out),
    .flush_addrs_out    (flush_addrs_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit in_rob(input int ix);
    foreach (rob_q[k]) if (rob_q[k] == ix) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compareAll();
    bit exp_ready;
    exp_ready = in_rob(int'(lookup_ix_in)) && m_ready[lookup_ix_in];
    checkOutput("alloc_ix", alloc_rob_ix_out, tail_m);
    checkOutput("full", full_out, rob_q.size() == 8);
    checkOutput("empty", empty_out, rob_q.size() == 0);
    checkOutput("lookup_ready", lookup_ready_out, exp_ready);
    if (exp_ready) checkOutput("lookup_value", lookup_value_out, m_val[lookup_ix_in]);
    checkOutput("we", we_out, e_we);
    if (e_we) begin
      checkOutput("wa", wa_out, e_wa);
      checkOutput("wd", wd_out, e_wd);
      checkOutput("wrob_ix", wrob_ix_out, e_wix);
    end
    checkOutput("flush", flush_out, e_flush);
    checkOutput("flush_addrs", flush_addrs_out, e_addrs);
  endtask

  // Advance the model by one clock edge using the inputs presented to the DUT.
  task automatic modelStep();
    bit full_before, flush_before, commit;
    int h;
    if (rst_in) begin
      rob_q.delete();
      tail_m = 0; e_we = 0; e_flush = 0; e_wa = '0; e_wd = '0; e_wix = '0; e_addrs = '0;
      return;
    end
    full_before  = (rob_q.size() == 8);
    flush_before = e_flush;
    commit       = (rob_q.size() > 0) && m_ready[rob_q[0]];
    e_we = 0; e_flush = 0; e_addrs = '0;
    if (commit && m_mis[rob_q[0]]) begin
      e_flush = 1;
      for (int k = 1; k < rob_q.size(); k++)
        if (m_wr[rob_q[k]]) e_addrs[rob_q[k]*5 +: 5] = m_rd[rob_q[k]];
      rob_q.delete();
      tail_m = 0;
      return;
    end
    if (commit) begin
      h     = rob_q[0];
      e_we  = m_wr[h] && (m_rd[h] != 0);
      e_wa  = m_rd[h];
      e_wd  = m_val[h];
      e_wix = 3'(h);
    end
    if (cdb_valid_in && in_rob(int'(cdb_rob_ix_in))) begin
      m_ready[cdb_rob_ix_in] = 1;
      m_val[cdb_rob_ix_in]   = cdb_value_in;
      m_mis[cdb_rob_ix_in]   = cdb_mispredict_in;
    end
    if (commit) void'(rob_q.pop_front());
    if (alloc_valid_in && !full_before && !flush_before) begin
      rob_q.push_back(tail_m);
      m_ready[tail_m] = 0;
      m_mis[tail_m]   = 0;
      m_rd[tail_m]    = alloc_rd_in;
      m_wr[tail_m]    = alloc_writes_rd_in;
      tail_m          = (tail_m + 1) % 8;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit av, input logic [4:0] ard, input bit awr,
                               input bit cv, input logic [2:0] cix, input logic [31:0] cval,
                               input bit cmis, input logic [2:0] lix);
    @(negedge clk_in);
    rst_in = rst; alloc_valid_in = av; alloc_rd_in = ard; alloc_writes_rd_in = awr;
    cdb_valid_in = cv; cdb_rob_ix_in = cix; cdb_value_in = cval; cdb_mispredict_in = cmis;
    lookup_ix_in = lix;
    #1;
    compareAll();
    @(posedge clk_in);
    modelStep();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 5'd0, 0, 0, 3'd0, 32'd0, 0, 3'd0);
  endtask
  task automatic doReset();
    applyStimulus(1, 0, 5'd0, 0, 0, 3'd0, 32'd0, 0, 3'd0);
  endtask
  task automatic alloc(input logic [4:0] rd, input bit wr);
    applyStimulus(0, 1, rd, wr, 0, 3'd0, 32'd0, 0, 3'd0);
  endtask
  task automatic cdb(input logic [2:0] ix, input logic [31:0] val, input bit mis);
    applyStimulus(0, 0, 5'd0, 0, 1, ix, val, mis, ix);
  endtask

  initial begin
    rst_in = 1; alloc_valid_in = 0; alloc_rd_in = '0; alloc_writes_rd_in = 0;
    cdb_valid_in = 0; cdb_rob_ix_in = '0; cdb_value_in = '0; cdb_mispredict_in = 0;
    lookup_ix_in = '0;
    repeat (2) @(posedge clk_in);
    modelStep();
    #1;
    checkOutput("reset_empty", empty_out, 1);
    checkOutput("reset_full", full_out, 0);
    checkOutput("reset_we", we_out, 0);
    checkOutput("reset_flush", flush_out, 0);

    // Single instruction through to register-file write.
    doReset();
    alloc(5'd5, 1);
    cdb(3'd0, 32'hDEADBEEF, 0);
    idle();
    #1;
    checkOutput("basic_we", we_out, 1);
    checkOutput("basic_wa", wa_out, 5);
    checkOutput("basic_wd", wd_out, 32'hDEADBEEF);
    checkOutput("basic_wix", wrob_ix_out, 0);

    // Fill, reject, drain one.
    doReset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1), 1);
    #1 checkOutput("fill_full", full_out, 1);
    alloc(5'd9, 1);
    #1;
    checkOutput("ninth_full", full_out, 1);
    checkOutput("ninth_tail", alloc_rob_ix_out, 0);
    cdb(3'd0, 32'h11, 0);
    idle();
    #1 checkOutput("drain_full", full_out, 0);

    // Out-of-order completion, in-order retirement.
    doReset();
    for (int i = 0; i < 3; i++) alloc(5'(i + 10), 1);
    cdb(3'd2, 32'h22, 0);
    cdb(3'd1, 32'h21, 0);
    cdb(3'd0, 32'h20, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      #1;
      checkOutput("order_we", we_out, 1);
      checkOutput("order_wix", wrob_ix_out, i);
      checkOutput("order_wd", wd_out, 32'h20 + i);
    end

    // Mispredicted branch flush.
    doReset();
    alloc(5'd0, 0);
    alloc(5'd3, 1);
    alloc(5'd7, 1);
    cdb(3'd0, 32'h0, 1);
    idle();
    #1;
    checkOutput("mis_flush", flush_out, 1);
    checkOutput("mis_we", we_out, 0);
    checkOutput("mis_addrs", flush_addrs_out, {25'd0, 5'd7, 5'd3, 5'd0});
    checkOutput("mis_empty", empty_out, 1);

    // Index wrap-around and x0 destination.
    doReset();
    for (int i = 0; i < 12; i++) begin
      #1 checkOutput("wrap_ix", alloc_rob_ix_out, i % 8);
      alloc(5'd4, 1);
      cdb(3'(i % 8), 32'(i), 0);
      idle();
    end
    alloc(5'd0, 1);
    cdb(3'd4, 32'h55, 0);
    idle();
    #1 checkOutput("x0_we", we_out, 0);

    // Reset wins over pending work.
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1);
    applyStimulus(1, 1, 5'd9, 1, 1, 3'd5, 32'h77, 0, 3'd5);
    #1;
    checkOutput("rst_empty", empty_out, 1);
    checkOutput("rst_we", we_out, 0);
    checkOutput("rst_flush", flush_out, 0);
    checkOutput("rst_wa", wa_out, 0);
    checkOutput("rst_wd", wd_out, 0);
    checkOutput("rst_wix", wrob_ix_out, 0);
    checkOutput("rst_addrs", flush_addrs_out, 0);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      bit          r_rst, r_av, r_awr, r_cv, r_mis;
      logic [2:0]  r_cix;
      r_rst = ($urandom % 150) == 0;
      r_av  = ($urandom % 4) != 0;
      r_awr = ($urandom % 4) != 0;
      r_cv  = ($urandom % 3) != 0;
      r_mis = ($urandom % 24) == 0;
      if (rob_q.size() > 0 && ($urandom % 4) != 0)
        r_cix = 3'(rob_q[$urandom % rob_q.size()]);
      else
        r_cix = 3'($urandom % 8);
      applyStimulus(r_rst, r_av, 5'($urandom), r_awr, r_cv, r_cix, $urandom, r_mis, 3'($urandom));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reorder_buffer

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of ROB entries; fixed at 8 to match the 3-bit register-file rob_ix.
REQ-002 SHALL have clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have alloc_valid_in  input  1  issue stage requests an entry this cycle.
REQ-005 SHALL have alloc_rd_in  input  5  destination register of the issuing instruction.
REQ-006 SHALL have alloc_writes_rd_in  input  1  instruction writes the register file.
REQ-007 SHALL have alloc_rob_ix_out  output  3  index granted to the issuing instruction (= tail).
REQ-008 SHALL have full_out / empty_out  output  1 each  occupancy flags.
REQ-009 SHALL have cdb_valid_in, cdb_rob_ix_in[2:0], cdb_value_in[31:0], cdb_mispredict_in  inputs  result broadcast.
REQ-010 SHALL have lookup_ix_in[2:0] input; lookup_ready_out[1] and lookup_value_out[32] outputs  operand bypass read.
REQ-011 SHALL have we_out[1], wa_out[5], wd_out[32], wrob_ix_out[3]  outputs  commit write to the register file.
REQ-012 SHALL have flush_out[1] and flush_addrs_out[8][5]  outputs  flush pulse and per-entry register addresses to clear.

Function
REQ-013 SHALL be a circular buffer: head (oldest), tail (next free), 4-bit count; head/tail wrap 7->0.
REQ-014 Each entry SHALL hold valid, ready, rd, writes_rd, value, mispredict.
REQ-015 full_out SHALL be count==8 and empty_out SHALL be count==0, both combinational from registered state.
REQ-016 alloc_rob_ix_out SHALL equal tail combinationally; allocation SHALL be accepted iff alloc_valid_in && !full_out && !flush_out.
REQ-017 An accepted allocation SHALL set entry[tail] valid=1, ready=0, mispredict=0, rd and writes_rd captured, and SHALL advance tail by 1.
REQ-018 On cdb_valid_in with entry[cdb_rob_ix_in] valid, the entry SHALL set ready=1, value=cdb_value_in, mispredict=cdb_mispredict_in; a CDB to an invalid entry SHALL be ignored.
REQ-019 lookup_ready_out SHALL be entry[lookup_ix_in].valid && ready; lookup_value_out SHALL be its value; both combinational with no same-cycle CDB bypass.
REQ-020 Commit SHALL occur when entry[head] is valid and ready (registered ready only); at most one commit per cycle.
REQ-021 A non-mispredict commit SHALL, next cycle, pulse we_out for one cycle iff writes_rd && rd!=0, with wa_out=rd, wd_out=value, wrob_ix_out=head index; the entry SHALL be invalidated and head SHALL advance.
REQ-022 A mispredict commit SHALL NOT assert we_out; it SHALL, next cycle, pulse flush_out for one cycle.
REQ-023 With the flush pulse, flush_addrs_out[i] SHALL be rd of entry i if that entry was valid, writes_rd, and not the committing entry; otherwise 0.
REQ-024 A mispredict commit SHALL invalidate all entries and set head=tail=count=0 in the same edge; allocation and CDB in that cycle SHALL be dropped.
REQ-025 Simultaneous accepted allocation and commit SHALL leave count unchanged; a full buffer SHALL NOT accept an allocation in the same cycle a commit frees a slot.
REQ-026 A CDB to the head entry SHALL make it commit no earlier than the following cycle.
REQ-027 we_out and flush_out SHALL never be high in the same cycle.

Reset
REQ-028 On rst_in, all entries SHALL be invalid, head=tail=count=0, we_out=0, flush_out=0, wa_out=0, wd_out=0, wrob_ix_out=0, flush_addrs_out all 0.
REQ-029 Reset SHALL take priority over commit, CDB, allocation and flush in the same cycle; in-flight entries SHALL be discarded.

Structure
REQ-030 A shared package SHALL hold ROB_DEPTH=8, ROB_IX_W=3, REG_ADDR_W=5, XLEN=32 and the rob_entry_t struct.
REQ-031 SHALL be a single module with no sub-modules; the entry array is in-module flops.

Verification
REQ-032 Reset, then alloc rd=5 -> alloc_rob_ix_out=0; CDB ix0 value 0xDEADBEEF -> next cycle commit, following cycle we_out=1, wa_out=5, wd_out=0xDEADBEEF, wrob_ix_out=0.
REQ-033 Alloc 8 entries -> full_out=1; ninth alloc rejected, tail stays 0; commit one -> full_out=0 the cycle after.
REQ-034 Alloc ix0..2; CDB ix2 then ix1 then ix0 -> commits in order 0,1,2 on consecutive cycles.
REQ-035 Alloc branch ix0, rd=3 at ix1, rd=7 at ix2; CDB ix0 mispredict -> flush_out pulse, flush_addrs_out[1]=3, [2]=7, others 0, no we_out, empty_out=1 after.
REQ-036 Wrap test: 12 alloc/commit pairs -> indices 0..7,0..3 granted; alloc with rd=0, writes_rd=1 -> commit with we_out=0.
REQ-037 rst_in asserted with 4 valid entries and a CDB pending -> next cycle empty_out=1, all outputs at reset values.
